// File: rtl/full_adder_8bit_pkg.sv
// Shared constants for the registered byte adder.
package full_adder_8bit_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage : full_adder_8bit_pkg

// File: rtl/full_adder_cell.sv
// Single-bit combinational full adder: one link of the ripple-carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the three-way parity; carry is the majority of the three inputs.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule : full_adder_cell

// File: rtl/full_adder_8bit.sv
// Registered WIDTH-bit ripple-carry adder: {Co,S} <= A + B + Cin, one-cycle latency.
module full_adder_8bit
    import full_adder_8bit_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = Cin;

    // Carry chain: each cell's carry-out feeds the next cell's carry-in.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    // Output register; synchronous reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            S  <= '0;
            Co <= 1'b0;
        end else begin
            S  <= sum;
            Co <= carry[WIDTH];
        end
    end

endmodule : full_adder_8bit

// File: tb/tb_full_adder_8bit.sv
// Scoreboard bench for the registered byte adder.
module tb_full_adder_8bit;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Co;

    int unsigned errors;
    int unsigned checks;

    logic [WIDTH:0] exp_q[$];
    string          tag_q[$];

    full_adder_8bit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Cin (Cin),
        .S   (S),
        .Co  (Co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {Co,S}=%h expected %h", tag, got, exp);
        end
    endtask

    // Drive one vector mid-cycle, push its expected result, then compare after the capturing edge.
    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic r, input string tag);
        logic [WIDTH:0] exp;
        string          t;
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        rst = r;
        exp = r ? '0 : ((WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin));
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty, got %h expected an entry", tag, {Co, S});
        end else begin
            exp = exp_q.pop_front();
            t   = tag_q.pop_front();
            check(t, {Co, S}, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        A      = '0;
        B      = '0;
        Cin    = 1'b0;

        // Reset for two cycles, then zero add
        drive(8'h00, 8'h00, 1'b0, 1'b1, "reset0");
        drive(8'h00, 8'h00, 1'b0, 1'b1, "reset1");
        for (int i = 0; i < 3; i++) drive(8'h00, 8'h00, 1'b0, 1'b0, "zero_add");

        // Directed corners
        drive(8'hFF, 8'h00, 1'b0, 1'b0, "pass_through");
        drive(8'hFF, 8'h00, 1'b1, 1'b0, "ripple_wrap");
        drive(8'hFF, 8'hFF, 1'b1, 1'b0, "max_sum");
        drive(8'h80, 8'h80, 1'b0, 1'b0, "msb_carry");
        drive(8'h55, 8'hAA, 1'b1, 1'b0, "alt_bits_cin");
        drive(8'h0F, 8'h01, 1'b0, 1'b0, "nibble_carry");

        // Reset mid-stream with inputs held
        drive(8'hFF, 8'hFF, 1'b1, 1'b0, "pre_reset");
        drive(8'hFF, 8'hFF, 1'b1, 1'b1, "mid_reset");
        drive(8'hFF, 8'hFF, 1'b1, 1'b0, "post_reset");

        // Full A sweep against boundary B values, both carry-ins
        for (int a = 0; a < 256; a++) begin
            for (int c = 0; c < 2; c++) begin
                drive(8'(a), 8'hFF, 1'(c), 1'b0, "sweep_b_ff");
                drive(8'(a), 8'h01, 1'(c), 1'b0, "sweep_b_01");
            end
        end

        // Random vectors with occasional reset pulses
        for (int i = 0; i < 20000; i++) begin
            drive(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 99) == 0), "random");
        end

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_full_adder_8bit
